// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the clock-divider rate controller.
// Holds the handshake state encoding, default geometry and the tick mask helper.
package clkdiv_pkg;

    localparam int DEF_N_TAPS = 4;
    localparam int DEF_SEL_W  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    // Low-bit mask covering cnt[i:0]; tap i ends its period when these bits are all ones.
    function automatic logic [31:0] ones_mask(input int unsigned i);
        return (32'd1 << (i + 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/clkdiv_counter.sv
// Run-gated free-running divider counter shared by all taps.
// wrap marks the edge on which the counter returns to zero.
module clkdiv_counter #(
    parameter int N_TAPS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic [N_TAPS-1:0] cnt,
    output logic              wrap
);

    logic [N_TAPS-1:0] cnt_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (run) begin
            cnt_reg <= cnt_reg + N_TAPS'(1);
        end
    end

    assign cnt  = cnt_reg;
    assign wrap = run & (&cnt_reg);

endmodule

// File: rtl/clkdiv_rate_ctrl.sv
// Clock-divider sequencer: per-tap tick strobes, one registered divided clock,
// and a req/ack rate-change handshake that only commits at counter wrap.
module clkdiv_rate_ctrl
    import clkdiv_pkg::*;
#(
    parameter int N_TAPS  = DEF_N_TAPS,
    parameter int SEL_W   = DEF_SEL_W,
    parameter int RST_SEL = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              sel_req,
    input  logic [SEL_W-1:0]  sel_val,
    output logic              sel_ack,
    output logic              sel_busy,
    output logic [SEL_W-1:0]  cur_sel,
    output logic [N_TAPS-1:0] tick,
    output logic              tick_sel,
    output logic              div_clk
);

    logic [N_TAPS-1:0] cnt;
    logic [N_TAPS-1:0] cnt_next;
    logic              wrap;

    state_t            state_reg, state_next;
    logic [SEL_W-1:0]  cur_sel_reg, cur_sel_next;
    logic [SEL_W-1:0]  pend_sel_reg, pend_sel_next;
    logic [SEL_W-1:0]  sel_clamped;
    logic              div_clk_reg;

    clkdiv_counter #(
        .N_TAPS (N_TAPS)
    ) u_counter (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .cnt   (cnt),
        .wrap  (wrap)
    );

    assign cnt_next = run ? cnt + N_TAPS'(1) : cnt;

    // Out-of-range requests fall back to the slowest tap.
    assign sel_clamped = (int'({1'b0, sel_val}) >= N_TAPS) ? SEL_W'(N_TAPS - 1) : sel_val;

    generate
        for (genvar gi = 0; gi < N_TAPS; gi++) begin : g_tick
            localparam logic [N_TAPS-1:0] TAP_MASK = N_TAPS'(ones_mask(gi));
            assign tick[gi] = run & ((cnt & TAP_MASK) == TAP_MASK);
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            cur_sel_reg  <= SEL_W'(RST_SEL);
            pend_sel_reg <= SEL_W'(RST_SEL);
            div_clk_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cur_sel_reg  <= cur_sel_next;
            pend_sel_reg <= pend_sel_next;
            // Track the tap bit the counter will hold after this edge, so a commit
            // on the wrap edge starts the new rate from a clean low phase.
            div_clk_reg  <= cnt_next[cur_sel_next];
        end
    end

    always_comb begin
        state_next    = state_reg;
        cur_sel_next  = cur_sel_reg;
        pend_sel_next = pend_sel_reg;
        sel_ack       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (sel_req) begin
                    pend_sel_next = sel_clamped;
                    state_next    = (sel_clamped == cur_sel_reg) ? ACK : WAIT;
                end
            end
            WAIT: begin
                if (wrap) begin
                    cur_sel_next = pend_sel_reg;
                    state_next   = ACK;
                end
            end
            ACK: begin
                sel_ack = 1'b1;
                if (!sel_req) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign sel_busy = (state_reg != IDLE);
    assign cur_sel  = cur_sel_reg;
    assign tick_sel = tick[cur_sel_reg];
    assign div_clk  = div_clk_reg;

endmodule

// File: tb/tb_clkdiv_rate_ctrl.sv
// Self-checking bench for clkdiv_rate_ctrl: directed scenarios plus random
// run/request traffic, all checked against an arithmetic reference model.
module tb_clkdiv_rate_ctrl;

    localparam int N_TAPS = 4;
    localparam int SEL_W  = 2;
    localparam int PERIOD = 1 << N_TAPS;

    logic              clk = 1'b0;
    logic              reset;
    logic              run;
    logic              sel_req;
    logic [SEL_W-1:0]  sel_val;
    logic              sel_ack;
    logic              sel_busy;
    logic [SEL_W-1:0]  cur_sel;
    logic [N_TAPS-1:0] tick;
    logic              tick_sel;
    logic              div_clk;

    int total = 0;
    int bad   = 0;

    // Reference model: counter value, active tap, request progress.
    int m_cnt;
    int m_sel;
    int m_pend;
    bit m_pending;   // request latched, waiting for wrap
    bit m_acking;    // acknowledge being shown

    always #5 clk = ~clk;

    clkdiv_rate_ctrl #(
        .N_TAPS  (N_TAPS),
        .SEL_W   (SEL_W),
        .RST_SEL (0)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .sel_req  (sel_req),
        .sel_val  (sel_val),
        .sel_ack  (sel_ack),
        .sel_busy (sel_busy),
        .cur_sel  (cur_sel),
        .tick     (tick),
        .tick_sel (tick_sel),
        .div_clk  (div_clk)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clamp_sel(input int v);
        return (v >= N_TAPS) ? N_TAPS - 1 : v;
    endfunction

    function automatic logic [N_TAPS-1:0] exp_tick();
        logic [N_TAPS-1:0] t;
        t = '0;
        for (int i = 0; i < N_TAPS; i++) begin
            int p;
            p = 1 << (i + 1);
            t[i] = run && ((m_cnt % p) == p - 1);
        end
        return t;
    endfunction

    task automatic model_reset();
        m_cnt     = 0;
        m_sel     = 0;
        m_pend    = 0;
        m_pending = 1'b0;
        m_acking  = 1'b0;
    endtask

    task automatic model_edge();
        bit at_wrap;
        at_wrap = run && (m_cnt == PERIOD - 1);
        if (m_acking) begin
            if (!sel_req) m_acking = 1'b0;
        end else if (m_pending) begin
            if (at_wrap) begin
                m_sel     = m_pend;
                m_pending = 1'b0;
                m_acking  = 1'b1;
            end
        end else if (sel_req) begin
            m_pend = clamp_sel(int'(sel_val));
            if (m_pend == m_sel) m_acking = 1'b1;
            else                 m_pending = 1'b1;
        end
        if (run) m_cnt = (m_cnt + 1) % PERIOD;
    endtask

    task automatic check_outputs();
        logic [N_TAPS-1:0] et;
        et = exp_tick();
        check_val("cur_sel",  32'(cur_sel),  32'(m_sel));
        check_val("sel_ack",  32'(sel_ack),  32'(m_acking));
        check_val("sel_busy", 32'(sel_busy), 32'(m_acking || m_pending));
        check_val("tick",     32'(tick),     32'(et));
        check_val("tick_sel", 32'(tick_sel), 32'(et[m_sel]));
        check_val("div_clk",  32'(div_clk),  32'((m_cnt >> m_sel) & 1));
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) model_reset();
        else       model_edge();
        #1;
        check_outputs();
    endtask

    task automatic wait_ack(input int budget, output int n);
        n = 0;
        while (sel_ack !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        if (sel_ack !== 1'b1) check_val("ack_timeout", 32'(sel_ack), 32'd1);
        else $display("handshake: sel_val=%0d acked after %0d edges, cur_sel=%0d", sel_val, n, cur_sel);
    endtask

    task automatic drop_req();
        sel_req = 1'b0;
        step();
    endtask

    initial begin
        int n, cnt_a, cnt_b, last_rise, k, exp_n;
        logic prev;

        // 1. Reset with run high, then free running on tap 0
        reset = 1'b1; run = 1'b1; sel_req = 1'b0; sel_val = '0;
        model_reset();
        #1;
        check_outputs();
        repeat (3) step();
        reset = 1'b0;
        cnt_a = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (tick[0]) cnt_a++;
        end
        check_val("tick0_count_8", 32'(cnt_a), 32'd4);

        // 2. Free-run taps over two full counter periods
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 2 * PERIOD; i++) begin
            step();
            if (tick[3]) begin
                cnt_a++;
                check_val("tick3_at_15", 32'(m_cnt), 32'd15);
            end
            if (tick[1]) cnt_b++;
        end
        check_val("tick3_count", 32'(cnt_a), 32'd2);
        check_val("tick1_count", 32'(cnt_b), 32'd8);

        // 3. Rate switch requested at cnt=5 commits on the wrap edge
        n = 0;
        while (m_cnt != 5 && n < 2 * PERIOD) begin step(); n++; end
        sel_req = 1'b1; sel_val = 2'd3;
        wait_ack(40, n);
        check_val("switch_latency", 32'(n), 32'(PERIOD - 5));
        check_val("switch_cur_sel", 32'(cur_sel), 32'd3);
        drop_req();
        last_rise = -1;
        for (k = 0; k < 40; k++) begin
            prev = div_clk;
            step();
            if (!prev && div_clk) begin
                if (last_rise >= 0) check_val("div_period_16", 32'(k - last_rise), 32'd16);
                last_rise = k;
            end
        end

        // 4. Same-tap request acknowledges after a single edge
        sel_req = 1'b1; sel_val = 2'd2;
        wait_ack(40, n);
        drop_req();
        sel_req = 1'b1; sel_val = 2'd2;
        wait_ack(40, n);
        check_val("same_tap_latency", 32'(n), 32'd1);
        drop_req();

        // 5. Stall while waiting: no commit until the counter runs again
        sel_req = 1'b1; sel_val = 2'd1;
        if (m_cnt == PERIOD - 1) step();
        step();
        run = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check_val("stall_busy", 32'(sel_busy), 32'd1);
            check_val("stall_ack",  32'(sel_ack),  32'd0);
        end
        exp_n = PERIOD - m_cnt;
        run = 1'b1;
        wait_ack(40, n);
        check_val("stall_resume_latency", 32'(n), 32'(exp_n));
        drop_req();

        // 6. Reset while a new tap is pending; held request re-accepted after release
        sel_req = 1'b1; sel_val = 2'd3;
        if (m_cnt == PERIOD - 1) step();
        step();
        run = 1'b0;
        step();
        check_val("pre_reset_busy", 32'(sel_busy), 32'd1);
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        step();
        reset = 1'b0;
        step();
        check_val("reaccept_busy", 32'(sel_busy), 32'd1);
        check_val("reaccept_ack",  32'(sel_ack),  32'd0);
        run = 1'b1;
        wait_ack(40, n);
        check_val("reaccept_cur_sel", 32'(cur_sel), 32'd3);
        drop_req();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            run = ($urandom_range(0, 7) != 0);
            if (!sel_req) begin
                if ($urandom_range(0, 3) == 0) begin
                    sel_req = 1'b1;
                    sel_val = SEL_W'($urandom_range(0, N_TAPS - 1));
                end
            end else if (sel_ack && $urandom_range(0, 1) == 0) begin
                sel_req = 1'b0;
            end else if ($urandom_range(0, 15) == 0) begin
                sel_val = SEL_W'($urandom_range(0, N_TAPS - 1));
            end
            step();
            if (sel_ack && !m_pending && $urandom_range(0, 3) == 0)
                $display("random handshake: cur_sel=%0d at edge %0d", cur_sel, i);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
